// File: rtl/reset_sequencer.sv
// reset_sequencer
// Staged reset generator. Keeps NUM_STAGES active-high reset outputs asserted
// until the synchronised lock input has been stable for HOLD_CYCLES, then
// releases them one by one in index order, STAGE_GAP cycles apart. Loss of
// lock or a software request re-asserts every stage and bumps a saturating
// event counter.
//
// Handshake note: this block has no valid/ready transfer interface. 'ready'
// is a level status: it is high exactly while the sequencer sits in RUN with
// every stage released, and drops on the same edge that re-asserts resets.

module reset_sequencer #(
   parameter int NUM_STAGES  = 3,
   parameter int HOLD_CYCLES = 8,
   parameter int STAGE_GAP   = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  lock_in,
   input  logic                  sw_reset,
   output logic [NUM_STAGES-1:0] rst_out,
   output logic                  ready,
   output logic [7:0]            reset_cnt
);

   // ------------------------------------------------------------------
   // Derived sizes and terminal values
   // ------------------------------------------------------------------
   localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int SW      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

   localparam logic [CW-1:0]         HOLD_LAST    = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0]         GAP_LAST     = CW'(STAGE_GAP - 1);
   localparam logic [SW-1:0]         STAGE_LAST   = SW'(NUM_STAGES - 1);
   localparam logic [NUM_STAGES-1:0] ALL_ASSERTED = '1;
   localparam logic [7:0]            RCNT_MAX     = 8'hFF;

   // FSM encoding
   localparam logic [1:0] ST_ASSERT  = 2'd0;
   localparam logic [1:0] ST_RELEASE = 2'd1;
   localparam logic [1:0] ST_RUN     = 2'd2;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   lock_sync;

   logic [1:0]            state_q,  state_d;
   logic [CW-1:0]         cnt_q,    cnt_d;
   logic [SW-1:0]         stage_q,  stage_d;
   logic [NUM_STAGES-1:0] rst_q,    rst_d;
   logic                  ready_q,  ready_d;
   logic [7:0]            rcnt_q,   rcnt_d;
   logic                  abort;

   // Multi-flop synchroniser for the asynchronous lock input; the newest
   // sample enters at bit 0 and the last flop feeds the FSM.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], lock_in};
      end
   end

   assign lock_sync = sync_q[SYNC_STAGES-1];

   // Any reason to (re)enter the all-asserted state.
   assign abort = !lock_sync || sw_reset;

   // Next-state logic: hold count in ASSERT, staged release, static RUN.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stage_d = stage_q;
      rst_d   = rst_q;
      ready_d = ready_q;
      rcnt_d  = rcnt_q;

      case (state_q)
         ST_ASSERT: begin
            rst_d   = ALL_ASSERTED;
            ready_d = 1'b0;
            stage_d = '0;
            if (abort) begin
               cnt_d = '0;
            end else if (cnt_q == HOLD_LAST) begin
               // Lock has been good long enough: release stage 0 now.
               cnt_d    = '0;
               rst_d[0] = 1'b0;
               if (NUM_STAGES == 1) begin
                  state_d = ST_RUN;
                  ready_d = 1'b1;
               end else begin
                  state_d = ST_RELEASE;
                  stage_d = SW'(1);
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         ST_RELEASE: begin
            if (abort) begin
               state_d = ST_ASSERT;
               rst_d   = ALL_ASSERTED;
               ready_d = 1'b0;
               cnt_d   = '0;
               stage_d = '0;
               if (rcnt_q != RCNT_MAX) rcnt_d = rcnt_q + 8'd1;
            end else if (cnt_q == GAP_LAST) begin
               cnt_d = '0;
               for (int i = 0; i < NUM_STAGES; i++) begin
                  if (stage_q == SW'(i)) rst_d[i] = 1'b0;
               end
               if (stage_q == STAGE_LAST) begin
                  // Final stage released; stage index stays put in RUN.
                  state_d = ST_RUN;
                  ready_d = 1'b1;
               end else begin
                  stage_d = stage_q + SW'(1);
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         ST_RUN: begin
            if (abort) begin
               state_d = ST_ASSERT;
               rst_d   = ALL_ASSERTED;
               ready_d = 1'b0;
               cnt_d   = '0;
               stage_d = '0;
               if (rcnt_q != RCNT_MAX) rcnt_d = rcnt_q + 8'd1;
            end
         end

         default: begin
            // Unreachable encoding: fall back to the safe, all-asserted state.
            state_d = ST_ASSERT;
            rst_d   = ALL_ASSERTED;
            ready_d = 1'b0;
            cnt_d   = '0;
            stage_d = '0;
         end
      endcase
   end

   // State registers; rst_n wins over every other input.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_ASSERT;
         cnt_q   <= '0;
         stage_q <= '0;
         rst_q   <= ALL_ASSERTED;
         ready_q <= 1'b0;
         rcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stage_q <= stage_d;
         rst_q   <= rst_d;
         ready_q <= ready_d;
         rcnt_q  <= rcnt_d;
      end
   end

   assign rst_out   = rst_q;
   assign ready     = ready_q;
   assign reset_cnt = rcnt_q;

   // ------------------------------------------------------------------
   // Structural invariants
   // ------------------------------------------------------------------

   // Released stages always form a contiguous group starting at bit 0.
   a_release_in_order : assert property (@(posedge clk) disable iff (!rst_n)
      (((~rst_q) & ((~rst_q) + NUM_STAGES'(1))) == '0));

   // ready only ever accompanies a fully released set of outputs.
   a_ready_all_released : assert property (@(posedge clk) disable iff (!rst_n)
      ready_q |-> (rst_q == '0));

   // Counters never pass their terminal values.
   a_hold_cnt_bound : assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == ST_ASSERT) |-> (cnt_q <= HOLD_LAST));

   a_gap_cnt_bound : assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == ST_RELEASE) |-> (cnt_q <= GAP_LAST));

endmodule
